// File: rtl/mips4_pkg.sv
// Shared definitions for the 4-bit MIPS ALU sequencer: opcodes, ALU op codes,
// instruction field positions, FSM states and the opcode decoder.
package mips4_pkg;

    localparam int INSTR_W = 13;

    localparam int OPC_MSB = 12;
    localparam int OPC_LSB = 10;
    localparam int RD_MSB  = 9;
    localparam int RD_LSB  = 8;
    localparam int RS_MSB  = 7;
    localparam int RS_LSB  = 6;
    localparam int RT_MSB  = 5;
    localparam int RT_LSB  = 4;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    typedef logic [2:0] opc_t;
    typedef logic [2:0] aluop_t;

    localparam opc_t OPC_ADD = 3'b000;
    localparam opc_t OPC_SUB = 3'b001;
    localparam opc_t OPC_AND = 3'b010;
    localparam opc_t OPC_OR  = 3'b011;
    localparam opc_t OPC_SLT = 3'b100;
    localparam opc_t OPC_BEQ = 3'b101;
    localparam opc_t OPC_LI  = 3'b110;
    localparam opc_t OPC_NOP = 3'b111;

    // bit 2 = b-invert / carry-in, bits 1:0 select and/or/sum/less
    localparam aluop_t ALUOP_AND = 3'b000;
    localparam aluop_t ALUOP_OR  = 3'b001;
    localparam aluop_t ALUOP_ADD = 3'b010;
    localparam aluop_t ALUOP_SUB = 3'b110;
    localparam aluop_t ALUOP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SRC_REG  = 2'd0,
        SRC_IMM  = 2'd1,
        SRC_ZERO = 2'd2
    } src_t;

    typedef struct packed {
        aluop_t alu_op;
        src_t   a_src;
        src_t   b_src;
        logic   wr_en;
        logic   is_beq;
    } dec_t;

    function automatic dec_t decode(input opc_t opc);
        dec_t d;
        d.alu_op = ALUOP_ADD;
        d.a_src  = SRC_REG;
        d.b_src  = SRC_REG;
        d.wr_en  = 1'b1;
        d.is_beq = 1'b0;
        case (opc)
            OPC_ADD: d.alu_op = ALUOP_ADD;
            OPC_SUB: d.alu_op = ALUOP_SUB;
            OPC_AND: d.alu_op = ALUOP_AND;
            OPC_OR:  d.alu_op = ALUOP_OR;
            OPC_SLT: d.alu_op = ALUOP_SLT;
            OPC_BEQ: begin
                d.alu_op = ALUOP_SUB;
                d.wr_en  = 1'b0;
                d.is_beq = 1'b1;
            end
            OPC_LI: begin
                d.alu_op = ALUOP_ADD;
                d.a_src  = SRC_ZERO;
                d.b_src  = SRC_IMM;
            end
            OPC_NOP: begin
                d.alu_op = ALUOP_AND;
                d.a_src  = SRC_ZERO;
                d.b_src  = SRC_ZERO;
                d.wr_en  = 1'b0;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mips4_alu_sequencer_if.sv
// Instruction handshake, ALU drive/return and retire signals of the sequencer.
// master = sequencer side, slave = instruction source plus attached ALU.
interface mips4_alu_sequencer_if #(
    parameter int WIDTH = 4
) ();

    logic                         instr_valid;
    logic [mips4_pkg::INSTR_W-1:0] instr;
    logic                         instr_ready;
    logic [2:0]                   alu_op;
    logic [WIDTH-1:0]             alu_a;
    logic [WIDTH-1:0]             alu_b;
    logic [WIDTH-1:0]             alu_result;
    logic                         alu_zero;
    logic                         done;
    logic [WIDTH-1:0]             res_data;
    logic                         branch_taken;

    modport master (
        input  instr_valid, instr, alu_result, alu_zero,
        output instr_ready, alu_op, alu_a, alu_b, done, res_data, branch_taken
    );

    modport slave (
        output instr_valid, instr, alu_result, alu_zero,
        input  instr_ready, alu_op, alu_a, alu_b, done, res_data, branch_taken
    );

endinterface

// File: rtl/mips4_regfile.sv
// Register file: two async read ports plus debug read, one sync write, r0 == 0.
// Latency: reads combinational, write visible the cycle after we; no backpressure.
module mips4_regfile #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    output logic [WIDTH-1:0]  rs_data,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [WIDTH-1:0]  rt_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [WIDTH-1:0]  dbg_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data
);

    localparam int NREG = 1 << ADDR_W;

    logic [WIDTH-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // r0 is forced on the read side so it reads zero regardless of storage
    assign rs_data  = (rs_addr  == '0) ? '0 : regs[rs_addr];
    assign rt_data  = (rt_addr  == '0) ? '0 : regs[rt_addr];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/mips4_alu_sequencer.sv
// Drives a combinational 4-bit MIPS ALU: fetch operands, execute, write back.
// Latency 3 cycles per instruction; instr_ready only in IDLE, no input buffering.
module mips4_alu_sequencer
    import mips4_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int REG_ADDR_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mips4_alu_sequencer_if.master bus,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [WIDTH-1:0]      dbg_data
);

    state_t                state_q;
    state_t                state_d;

    opc_t                  opc;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [REG_ADDR_W-1:0] rs_addr;
    logic [REG_ADDR_W-1:0] rt_addr;
    logic [WIDTH-1:0]      imm_ext;
    dec_t                  dec;

    logic [WIDTH-1:0]      rs_data;
    logic [WIDTH-1:0]      rt_data;
    logic [WIDTH-1:0]      a_nxt;
    logic [WIDTH-1:0]      b_nxt;

    aluop_t                alu_op_q;
    logic [WIDTH-1:0]      alu_a_q;
    logic [WIDTH-1:0]      alu_b_q;
    logic [WIDTH-1:0]      res_q;
    logic                  br_q;
    logic                  wr_en_q;
    logic                  beq_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  rf_we;

    assign opc     = bus.instr[OPC_MSB:OPC_LSB];
    assign rd_addr = REG_ADDR_W'(bus.instr[RD_MSB:RD_LSB]);
    assign rs_addr = REG_ADDR_W'(bus.instr[RS_MSB:RS_LSB]);
    assign rt_addr = REG_ADDR_W'(bus.instr[RT_MSB:RT_LSB]);
    assign imm_ext = WIDTH'(bus.instr[IMM_MSB:IMM_LSB]);
    assign dec     = decode(opc);

    mips4_regfile #(
        .WIDTH  (WIDTH),
        .ADDR_W (REG_ADDR_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs_addr  (rs_addr),
        .rs_data  (rs_data),
        .rt_addr  (rt_addr),
        .rt_data  (rt_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (rf_we),
        .wr_addr  (rd_q),
        .wr_data  (res_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        bus.instr_ready = 1'b0;
        bus.done        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_WB;
            ST_WB: begin
                bus.done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        a_nxt = rs_data;
        b_nxt = rt_data;
        if (dec.a_src == SRC_ZERO) begin
            a_nxt = '0;
        end
        case (dec.b_src)
            SRC_IMM:  b_nxt = imm_ext;
            SRC_ZERO: b_nxt = '0;
            default:  b_nxt = rt_data;
        endcase
    end

    // Operands are registered on accept so the ALU sees a stable input for all of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op_q <= ALUOP_AND;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            wr_en_q  <= 1'b0;
            beq_q    <= 1'b0;
            rd_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.instr_valid) begin
                        alu_op_q <= dec.alu_op;
                        alu_a_q  <= a_nxt;
                        alu_b_q  <= b_nxt;
                        wr_en_q  <= dec.wr_en;
                        beq_q    <= dec.is_beq;
                        rd_q     <= rd_addr;
                    end
                end
                ST_EXEC: begin
                    res_q <= bus.alu_result;
                    br_q  <= beq_q & bus.alu_zero;
                end
                ST_WB: begin
                    alu_op_q <= ALUOP_AND;
                    alu_a_q  <= '0;
                    alu_b_q  <= '0;
                end
                default: ;
            endcase
        end
    end

    // Writeback lands on the WB->IDLE edge, so debug reads see the old value during WB.
    assign rf_we            = (state_q == ST_WB) && wr_en_q;

    assign bus.alu_op       = alu_op_q;
    assign bus.alu_a        = alu_a_q;
    assign bus.alu_b        = alu_b_q;
    assign bus.res_data     = res_q;
    assign bus.branch_taken = br_q;

endmodule

// File: tb/tb_mips4_alu_sequencer.sv
// Bench for mips4_alu_sequencer with a behavioural 4-bit ALU and a result scoreboard.
module tb_mips4_alu_sequencer;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;

    mips4_alu_sequencer_if #(.WIDTH(4)) bus ();

    mips4_alu_sequencer #(
        .WIDTH      (4),
        .REG_ADDR_W (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural ALU: binvert/carry-in on op[2], select on op[1:0], set = sum msb
    logic [3:0] alu_bb;
    logic [3:0] alu_sum;
    always_comb begin
        alu_bb  = bus.alu_op[2] ? ~bus.alu_b : bus.alu_b;
        alu_sum = bus.alu_a + alu_bb + {3'b000, bus.alu_op[2]};
        case (bus.alu_op[1:0])
            2'b00:   bus.alu_result = bus.alu_a & alu_bb;
            2'b01:   bus.alu_result = bus.alu_a | alu_bb;
            2'b10:   bus.alu_result = alu_sum;
            default: bus.alu_result = {3'b000, alu_sum[3]};
        endcase
        bus.alu_zero = (bus.alu_result == 4'd0);
    end

    typedef struct {
        logic [3:0] res;
        logic       br;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] mreg[4];
    int         total = 0;
    int         bad   = 0;
    int         done_cnt = 0;
    int         exp_dones = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.done) begin
            exp_t e;
            done_cnt++;
            if (sb_q.size() == 0) begin
                check_val("spurious_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check_val("res_data", bus.res_data, e.res);
                check_val("branch_taken", bus.branch_taken, e.br);
            end
        end
    end

    // Issue one instruction from a negedge; returns at the negedge after writeback.
    task automatic issue(input logic [2:0] opc, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [1:0] rt, input logic [3:0] imm);
        logic [3:0] a, b, res, diff, old_v, new_v;
        logic [2:0] op;
        logic       br, wr;
        int         n;
        exp_t       e;
        n = 0;
        while (!bus.instr_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!bus.instr_ready) begin
            check_val("ready_timeout", 0, 1);
            return;
        end
        a    = mreg[rs];
        b    = mreg[rt];
        diff = a - b;
        br   = 1'b0;
        wr   = 1'b1;
        case (opc)
            3'b000:  begin op = 3'b010; res = a + b; end
            3'b001:  begin op = 3'b110; res = diff; end
            3'b010:  begin op = 3'b000; res = a & b; end
            3'b011:  begin op = 3'b001; res = a | b; end
            3'b100:  begin op = 3'b111; res = {3'b000, diff[3]}; end
            3'b101:  begin op = 3'b110; res = diff; br = (diff == 4'd0); wr = 1'b0; end
            3'b110:  begin op = 3'b010; a = 4'd0; b = imm; res = imm; end
            default: begin op = 3'b000; a = 4'd0; b = 4'd0; res = 4'd0; wr = 1'b0; end
        endcase
        old_v = mreg[rd];
        if (wr && rd != 2'd0) mreg[rd] = res;
        new_v = mreg[rd];

        dbg_addr        = rd;
        bus.instr       = {opc, rd, rs, rt, imm};
        bus.instr_valid = 1'b1;
        e.res = res;
        e.br  = br;
        sb_q.push_back(e);
        exp_dones++;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;

        @(negedge clk);
        check_val("exec_alu_op", bus.alu_op, op);
        check_val("exec_alu_a", bus.alu_a, a);
        check_val("exec_alu_b", bus.alu_b, b);
        check_val("exec_ready", bus.instr_ready, 0);
        n = 1;
        while (!bus.done && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            check_val("done_timeout", 0, 1);
            return;
        end
        check_val("latency", n, 2);
        check_val("wb_alu_op_held", bus.alu_op, op);
        check_val("wb_dbg_old", dbg_data, old_v);
        @(negedge clk);
        check_val("wb_dbg_new", dbg_data, new_v);
        check_val("idle_alu_op", bus.alu_op, 0);
        check_val("idle_alu_a", bus.alu_a, 0);
        check_val("idle_ready", bus.instr_ready, 1);
        check_val("idle_done", bus.done, 0);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1 check_val(tag, dbg_data, mreg[i]);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        int saved;
        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        dbg_addr        = 2'd0;
        for (int i = 0; i < 4; i++) mreg[i] = 4'd0;

        repeat (2) @(negedge clk);
        check_val("rst_ready", bus.instr_ready, 1);
        check_val("rst_done", bus.done, 0);
        check_val("rst_alu_op", bus.alu_op, 0);
        check_val("rst_alu_a", bus.alu_a, 0);
        check_val("rst_alu_b", bus.alu_b, 0);
        check_val("rst_res_data", bus.res_data, 0);
        check_val("rst_branch", bus.branch_taken, 0);
        check_regs("rst_reg");
        rst_n = 1'b1;
        @(negedge clk);

        issue(3'b110, 2'd1, 2'd0, 2'd0, 4'd5);   // LI r1,5
        issue(3'b110, 2'd2, 2'd0, 2'd0, 4'd3);   // LI r2,3
        issue(3'b000, 2'd3, 2'd1, 2'd2, 4'd0);   // ADD r3,r1,r2 -> 8
        issue(3'b001, 2'd3, 2'd2, 2'd1, 4'd0);   // SUB r3,r2,r1 -> E
        issue(3'b100, 2'd3, 2'd2, 2'd1, 4'd0);   // SLT r3,r2,r1 -> 1
        issue(3'b100, 2'd3, 2'd1, 2'd2, 4'd0);   // SLT r3,r1,r2 -> 0
        issue(3'b010, 2'd3, 2'd1, 2'd2, 4'd0);   // AND -> 1
        issue(3'b011, 2'd3, 2'd1, 2'd2, 4'd0);   // OR  -> 7
        issue(3'b101, 2'd0, 2'd1, 2'd1, 4'd0);   // BEQ r1,r1 taken
        issue(3'b101, 2'd0, 2'd1, 2'd2, 4'd0);   // BEQ r1,r2 not taken
        issue(3'b110, 2'd0, 2'd0, 2'd0, 4'd9);   // LI r0,9 discarded
        issue(3'b111, 2'd2, 2'd1, 2'd2, 4'd7);   // NOP, no write
        issue(3'b000, 2'd1, 2'd1, 2'd1, 4'd0);   // ADD r1,r1,r1 -> A
        issue(3'b000, 2'd3, 2'd1, 2'd1, 4'd0);   // wraps to 4
        check_regs("reg_after_ops");

        // valid held high: accepts only on IDLE cycles
        acc             = 0;
        bus.instr       = {3'b111, 10'd0};
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (bus.instr_ready) begin
                exp_t e;
                e.res = 4'd0;
                e.br  = 1'b0;
                sb_q.push_back(e);
                exp_dones++;
                acc++;
            end
            @(negedge clk);
        end
        bus.instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_val("held_accepts", acc, 3);

        // reset during EXEC discards the in-flight ADD
        saved           = done_cnt;
        dbg_addr        = 2'd3;
        bus.instr       = {3'b000, 2'd3, 2'd1, 2'd2, 4'd0};
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        @(negedge clk);
        check_val("pre_rst_exec_op", bus.alu_op, 3'b010);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_ready", bus.instr_ready, 1);
        check_val("mid_rst_alu_op", bus.alu_op, 0);
        check_val("mid_rst_done", bus.done, 0);
        for (int i = 0; i < 4; i++) mreg[i] = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_val("no_done_after_rst", done_cnt, saved);
        check_regs("reg_after_rst");
        issue(3'b110, 2'd1, 2'd0, 2'd0, 4'd2);   // LI r1,2
        issue(3'b001, 2'd2, 2'd0, 2'd1, 4'd0);   // SUB r2,r0,r1 -> E
        check_regs("reg_final");

        repeat (2) @(negedge clk);
        check_val("done_count", done_cnt, exp_dones);
        check_val("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
